timer_tick_scheduler: RTL and testbench
=======================================

# timer_tick_scheduler

Autonomous Avalon-MM master that programs and services the 16-bit-register interval timer peripheral, with no Nios II software involvement. It loads the period, starts the timer in continuous mode with interrupt enabled, and acknowledges every timeout. From the timeouts it produces a one-cycle tick, a 32-bit tick count and a divided pulse (e.g. 10 ms ticks into 1 s pulses). It also serves on-demand counter snapshots. It sits between the timer's s1 slave port and the LED/display logic in the Qsys system.

## Interface
- DEFAULT_PERIOD, 400000: cycles per tick used after reset (10 ms at 40 MHz).
- DIV, 100: ticks per div_pulse; legal range 1..65535.
- MIN_PERIOD, 16: smallest accepted cycles-per-tick.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high runs the timer, low stops it.
- cfg_period  in  32  cycles per tick; sampled only on a cfg_load pulse.
- cfg_load  in  1  single-cycle request to reprogram the period.
- snap_req  in  1  single-cycle request for a counter snapshot.
- snap_value  out  32  last snapshot value, held until the next snapshot.
- snap_valid  out  1  single-cycle strobe: snap_value was updated.
- tick  out  1  single-cycle strobe per timer timeout.
- tick_count  out  32  number of ticks, wraps at 2^32.
- div_pulse  out  1  single-cycle strobe on every DIV-th tick.
- busy  out  1  high in every state except IDLE and RUN.
- tmr_address  out  3  timer register index.
- tmr_chipselect  out  1.
- tmr_write_n  out  1  active-low write strobe.
- tmr_writedata  out  16.
- tmr_readdata  in  16  registered by the timer; valid one cycle after the address is presented.
- tmr_irq  in  1  level; cleared by any write to address 0.

## Operation
- Timer register map:
  - 0: status (write clears timeout).
  - 1: control. Bit 0 = ITO, bit 1 = CONT, bit 2 = START, bit 3 = STOP.
  - 2: period low. 3: period high.
  - 4/5: snapshot low/high. A write to either latches the counter.
- Bus outputs are Moore-decoded from the state register. One bus access per state; no waitrequest.
- Idle bus values: chipselect 0, write_n 1, address 0, writedata 0.
- Reads assert chipselect = 1 and write_n = 1.
- Period register P (32 bits) resets to DEFAULT_PERIOD.
- On cfg_load, P takes max(cfg_period, MIN_PERIOD).
- Programmed load value is P−1, because the timer counts load..0 inclusive.
- State machine:
  - IDLE: if enable → WR_STOP.
  - WR_STOP: write addr 1, data 0x0008.
  - WR_PL: write addr 2, data (P−1)[15:0].
  - WR_PH: write addr 3, data (P−1)[31:16].
  - WR_CTRL: write addr 1, data 0x0007 → RUN.
  - RUN: priority, highest first:
    1. tmr_irq → CLR.
    2. !enable → HALT.
    3. load_pend → WR_STOP.
    4. snap_pend → SN_WR.
  - CLR: write addr 0, data 0. Assert tick. Increment tick_count and the divider → RUN.
  - HALT: write addr 1, data 0x0008 → IDLE.
  - SN_WR: write addr 4 → SN_RL.
  - SN_RL: read addr 4 → SN_RH.
  - SN_RH: read addr 5. Capture tmr_readdata into snap_value[15:0] → SN_DONE.
  - SN_DONE: bus idle. Capture tmr_readdata into snap_value[31:16]. Assert snap_valid → RUN.
- Pending flags:
  - load_pend is set by cfg_load in any state. It is cleared on entry to WR_STOP.
  - snap_pend is set by snap_req in any state. It is cleared on entry to SN_WR.
  - A request in IDLE stays pending. cfg_load in IDLE updates P immediately.
- The WR_STOP → WR_PL → WR_PH → WR_CTRL order is mandatory, in consecutive cycles.
- Divider: 16-bit count 0..DIV−1. div_pulse asserts in the CLR cycle in which the count wraps to 0.
- Falling edge of enable: tick_count and the divider are retained, not cleared.

## Timing
- Reset values:
  - All strobes 0, busy 0.
  - tick_count 0, snap_value 0, divider 0.
  - State IDLE, P = DEFAULT_PERIOD, bus idle.
- enable sampled high at edge E0 → WR_STOP in cycle 1 … WR_CTRL in cycle 4.
- The timer runs from the edge ending cycle 4. The first tmr_irq is P cycles later.
- irq to tick latency: tick is asserted in the cycle after tmr_irq is first seen in RUN.
- tmr_irq falls the cycle after CLR, so it is never double-serviced.
- A timeout during a snapshot or a reprogram sequence stays latched in the timer. It is serviced on return to RUN, delayed ≤ 4 cycles, never lost.
  - This is guaranteed by P ≥ MIN_PERIOD.
- Snapshot latency: snap_valid is asserted 5 cycles after snap_req is sampled in RUN.
- tick_count wraps from 0xFFFFFFFF to 0 without any flag.
- Reset asserted mid-sequence: immediate return to IDLE with bus idle. The timer shares reset_n.

## Structure
- A shared package `timer_regs_pkg` holds:
  - the register address constants;
  - control bit positions and values (CTRL_RUN = 0x0007, CTRL_STOP = 0x0008);
  - the state enum.
- One sub-module, `tick_divider`: holds DIV, takes the tick input, produces div_pulse.
- Everything else is a single FSM plus datapath.

## Test plan
- Reset then enable = 1 (DEFAULT_PERIOD):
  - Bus writes, in consecutive cycles: (1, 0x0008), (2, 0x1A7F), (3, 0x0006), (1, 0x0007).
  - Ticks every 400000 cycles.
- cfg_load with cfg_period = 20 while running:
  - Reprogram writes (2, 0x0013), (3, 0x0000).
  - Then ticks every 20 cycles; tick_count increments by 1 per tick.
- DIV = 4, P = 20:
  - div_pulse on ticks 4, 8, 12.
  - No tick lost over 1000 cycles: tick_count = 50 ± 1.
- snap_req issued 2 cycles before a timeout (P = 20):
  - snap_valid 5 cycles later, snap_value ≤ 19.
  - The timeout's tick is still issued, within 4 cycles of its nominal time.
- cfg_period = 3: P is clamped to 16, so the load value written is 15.
- enable dropped mid-WR_PH:
  - Sequence completes, then RUN, then HALT writes (1, 0x0008), then IDLE.
  - tmr_irq never rises afterwards.
  - Separately, reset asserted in SN_RL leaves all outputs at their reset values.

Source files
------------

// File: rtl/timer_regs_pkg.sv
// Register map, control encodings and scheduler state type for the 16-bit interval timer
// peripheral that timer_tick_scheduler drives over Avalon-MM.
package timer_regs_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int unsigned CTRL_ITO_BIT   = 0;
  localparam int unsigned CTRL_CONT_BIT  = 1;
  localparam int unsigned CTRL_START_BIT = 2;
  localparam int unsigned CTRL_STOP_BIT  = 3;

  localparam logic [15:0] CTRL_RUN  = 16'((1 << CTRL_ITO_BIT) | (1 << CTRL_CONT_BIT) |
                                          (1 << CTRL_START_BIT));
  localparam logic [15:0] CTRL_STOP = 16'(1 << CTRL_STOP_BIT);

  typedef enum logic [3:0] {
    StIdle,
    StWrStop,
    StWrPl,
    StWrPh,
    StWrCtrl,
    StRun,
    StClr,
    StHalt,
    StSnWr,
    StSnRl,
    StSnRh,
    StSnDone
  } sched_state_e;

  function automatic logic [31:0] clamp_period(input logic [31:0] req,
                                               input logic [31:0] floor_val);
    return (req < floor_val) ? floor_val : req;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides the scheduler tick strobe by DIV; div_pulse fires on the tick that wraps the count.
module tick_divider #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  output logic div_pulse
);

  localparam logic [15:0] LastCount = 16'(DIV - 1);

  logic [15:0] count_q;
  logic        wrap;

  assign wrap      = (count_q == LastCount);
  assign div_pulse = tick & wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= wrap ? 16'd0 : count_q + 16'd1;
    end
  end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Autonomous Avalon-MM master: programs the interval timer, services its timeouts into ticks,
// a tick counter and a divided pulse, and reads counter snapshots on request.
module timer_tick_scheduler
  import timer_regs_pkg::*;
#(
  parameter int unsigned DEFAULT_PERIOD = 400000,
  parameter int unsigned DIV            = 100,
  parameter int unsigned MIN_PERIOD     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] cfg_period,
  input  logic        cfg_load,
  input  logic        snap_req,
  output logic [31:0] snap_value,
  output logic        snap_valid,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic        div_pulse,
  output logic        busy,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq
);

  sched_state_e state_q, state_d;

  logic [31:0] period_q;
  logic [31:0] load_val;
  logic        load_pend_q;
  logic        snap_pend_q;
  logic [31:0] tick_count_q;
  logic [15:0] snap_lo_q;
  logic [15:0] snap_hi_q;

  // The timer counts load..0 inclusive, so one less than the period is programmed.
  assign load_val = period_q - 32'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = StWrStop;
      StWrStop: state_d = StWrPl;
      StWrPl:   state_d = StWrPh;
      StWrPh:   state_d = StWrCtrl;
      StWrCtrl: state_d = StRun;
      StRun: begin
        if (tmr_irq)          state_d = StClr;
        else if (!enable)     state_d = StHalt;
        else if (load_pend_q) state_d = StWrStop;
        else if (snap_pend_q) state_d = StSnWr;
      end
      StClr:    state_d = StRun;
      StHalt:   state_d = StIdle;
      StSnWr:   state_d = StSnRl;
      StSnRl:   state_d = StSnRh;
      StSnRh:   state_d = StSnDone;
      StSnDone: state_d = StRun;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = ADDR_STATUS;
    tmr_writedata  = 16'h0000;
    unique case (state_q)
      StWrStop, StHalt: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = CTRL_STOP;
      end
      StWrPl: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIODL;
        tmr_writedata  = load_val[15:0];
      end
      StWrPh: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIODH;
        tmr_writedata  = load_val[31:16];
      end
      StWrCtrl: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = CTRL_RUN;
      end
      StClr: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_STATUS;
      end
      StSnWr: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_SNAPL;
      end
      StSnRl: begin
        tmr_chipselect = 1'b1;
        tmr_address    = ADDR_SNAPL;
      end
      StSnRh: begin
        tmr_chipselect = 1'b1;
        tmr_address    = ADDR_SNAPH;
      end
      default: ;
    endcase
  end

  assign tick       = (state_q == StClr);
  assign snap_valid = (state_q == StSnDone);
  assign busy       = (state_q != StIdle) && (state_q != StRun);
  assign tick_count = tick_count_q;
  // The high half arrives in SN_DONE itself, so it is forwarded while snap_valid is high.
  assign snap_value = {snap_valid ? tmr_readdata : snap_hi_q, snap_lo_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q     <= 32'(DEFAULT_PERIOD);
      load_pend_q  <= 1'b0;
      snap_pend_q  <= 1'b0;
      tick_count_q <= '0;
      snap_lo_q    <= '0;
      snap_hi_q    <= '0;
    end else begin
      if (cfg_load) period_q <= clamp_period(cfg_period, 32'(MIN_PERIOD));
      load_pend_q <= (state_d == StWrStop) ? 1'b0 : (load_pend_q | cfg_load);
      snap_pend_q <= (state_d == StSnWr) ? 1'b0 : (snap_pend_q | snap_req);
      if (state_q == StClr)    tick_count_q <= tick_count_q + 32'd1;
      if (state_q == StSnRh)   snap_lo_q    <= tmr_readdata;
      if (state_q == StSnDone) snap_hi_q    <= tmr_readdata;
    end
  end

  tick_divider #(
    .DIV(DIV)
  ) u_tick_divider (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .div_pulse(div_pulse)
  );

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Bench for timer_tick_scheduler: behavioural interval timer peripheral plus a tick/phase
// scoreboard derived from the timer period.
module tb_timer_tick_scheduler;

  localparam int unsigned DivTb = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] cfg_period;
  logic        cfg_load;
  logic        snap_req;
  logic [31:0] snap_value;
  logic        snap_valid;
  logic        tick;
  logic [31:0] tick_count;
  logic        div_pulse;
  logic        busy;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  timer_tick_scheduler #(
    .DEFAULT_PERIOD(400000),
    .DIV           (DivTb),
    .MIN_PERIOD    (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .cfg_period    (cfg_period),
    .cfg_load      (cfg_load),
    .snap_req      (snap_req),
    .snap_value    (snap_value),
    .snap_valid    (snap_valid),
    .tick          (tick),
    .tick_count    (tick_count),
    .div_pulse     (div_pulse),
    .busy          (busy),
    .tmr_address   (tmr_address),
    .tmr_chipselect(tmr_chipselect),
    .tmr_write_n   (tmr_write_n),
    .tmr_writedata (tmr_writedata),
    .tmr_readdata  (tmr_readdata),
    .tmr_irq       (tmr_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural interval timer peripheral.
  logic [31:0] t_period, t_count, t_snap;
  logic        t_run, t_to, t_ito, t_cont;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_period <= '0; t_count <= '0; t_snap <= '0; tmr_readdata <= '0;
      t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
    end else begin
      if (t_run) begin
        if (t_count == 0) begin
          t_count <= t_period;
          t_to    <= 1'b1;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_count <= t_count - 1;
        end
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito  <= tmr_writedata[0];
            t_cont <= tmr_writedata[1];
            if (tmr_writedata[3]) t_run <= 1'b0;
            else if (tmr_writedata[2]) t_run <= 1'b1;
          end
          3'd2: begin
            t_period[15:0] <= tmr_writedata;
            t_count <= {t_period[31:16], tmr_writedata};
            t_run <= 1'b0;
          end
          3'd3: begin
            t_period[31:16] <= tmr_writedata;
            t_count <= {tmr_writedata, t_period[15:0]};
            t_run <= 1'b0;
          end
          3'd4, 3'd5: t_snap <= t_count;
          default: ;
        endcase
      end
      if (tmr_chipselect && tmr_write_n) begin
        case (tmr_address)
          3'd4:    tmr_readdata <= t_snap[15:0];
          3'd5:    tmr_readdata <= t_snap[31:16];
          default: tmr_readdata <= 16'h0000;
        endcase
      end
    end
  end
  assign tmr_irq = t_to & t_ito;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {int c; logic [2:0] a; logic [15:0] d;} wr_t;
  wr_t wlog[$];
  int  div_at[$];

  int  n_ticks = 0, last_tick_cyc = 0, n_snaps = 0, snap_cyc = 0;
  logic [31:0] snap_val = '0;
  int  base = 0, cur_p = 1, n_since_base = 0, tol = 0;
  bit  phase_on = 0, halted_chk = 0, irq_after_halt = 0;

  // Scoreboard: every tick must sit on the timer's nominal grid (base + k*P) within tol.
  always @(negedge clk) begin
    if (reset_n) begin
      if (tmr_chipselect && !tmr_write_n) wlog.push_back('{cyc, tmr_address, tmr_writedata});
      if (tick) begin
        check("tick_count_at_tick", tick_count, n_ticks);
        check("div_pulse", {31'd0, div_pulse}, ((n_ticks + 1) % DivTb == 0) ? 1 : 0);
        if (div_pulse) div_at.push_back(n_ticks + 1);
        if (phase_on) begin
          check("tick_index", (cyc - base) / cur_p, n_since_base);
          check("tick_lateness", (((cyc - base) % cur_p) <= tol) ? 1 : 0, 1);
          n_since_base++;
        end
        n_ticks++;
        last_tick_cyc = cyc;
      end else if (div_pulse) begin
        check("div_pulse_without_tick", {31'd0, div_pulse}, 0);
      end
      if (snap_valid) begin
        snap_cyc = cyc;
        snap_val = snap_value;
        n_snaps++;
      end
      if (halted_chk && tmr_irq) irq_after_halt = 1;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wlog.size() < n && k < budget) begin cyc_wait(1); k++; end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [2:0] a,
                          input logic [15:0] d, input int gap);
    check({tag, "_present"}, (wlog.size() > idx) ? 1 : 0, 1);
    if (wlog.size() > idx) begin
      check({tag, "_addr"}, {29'd0, wlog[idx].a}, {29'd0, a});
      check({tag, "_data"}, {16'd0, wlog[idx].d}, {16'd0, d});
      if (gap > 0 && idx > 0) check({tag, "_gap"}, wlog[idx].c - wlog[idx - 1].c, gap);
    end
  endtask

  task automatic wait_tick(input string tag, input int budget);
    int t = n_ticks;
    int k = 0;
    while (n_ticks == t && k < budget) begin cyc_wait(1); k++; end
    check({tag, "_tick_in_time"}, (n_ticks != t) ? 1 : 0, 1);
  endtask

  task automatic start_phase(input int p);
    wait_tick("phase", 3 * p + 10);
    base = last_tick_cyc;
    cur_p = p;
    n_since_base = 1;
    tol = 0;
    phase_on = 1;
  endtask

  task automatic reprogram(input string tag, input logic [31:0] req, input logic [15:0] lo,
                           input logic [15:0] hi);
    int w0;
    if (phase_on) begin
      phase_on = 0;
      wait_tick({tag, "_sync"}, 80);
    end
    w0 = wlog.size();
    cfg_period = req;
    cfg_load = 1;
    cyc_wait(1);
    cfg_load = 0;
    wait_writes(w0 + 4, 20);
    check_wr({tag, "_stop"}, w0, 3'd1, 16'h0008, 0);
    check_wr({tag, "_pl"}, w0 + 1, 3'd2, lo, 1);
    check_wr({tag, "_ph"}, w0 + 2, 3'd3, hi, 1);
    check_wr({tag, "_ctrl"}, w0 + 3, 3'd1, 16'h0007, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"}, {31'd0, tick}, 0);
    check({tag, "_tick_count"}, tick_count, 0);
    check({tag, "_snap_value"}, snap_value, 0);
    check({tag, "_snap_valid"}, {31'd0, snap_valid}, 0);
    check({tag, "_div_pulse"}, {31'd0, div_pulse}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_cs"}, {31'd0, tmr_chipselect}, 0);
    check({tag, "_write_n"}, {31'd0, tmr_write_n}, 1);
    check({tag, "_addr"}, {29'd0, tmr_address}, 0);
    check({tag, "_wdata"}, {16'd0, tmr_writedata}, 0);
  endtask

  initial begin
    int w0, t0, k, c, off, lat, p, tc;
    reset_n = 0; enable = 0; cfg_period = '0; cfg_load = 0; snap_req = 0;
    cyc_wait(3);
    check_reset_outputs("reset");
    reset_n = 1;
    cyc_wait(2);
    check("idle_busy", {31'd0, busy}, 0);

    // Default period bring-up.
    enable = 1;
    wait_writes(4, 20);
    check_wr("boot_stop", 0, 3'd1, 16'h0008, 0);
    check_wr("boot_pl", 1, 3'd2, 16'h1A7F, 1);
    check_wr("boot_ph", 2, 3'd3, 16'h0006, 1);
    check_wr("boot_ctrl", 3, 3'd1, 16'h0007, 1);
    cyc_wait(5);
    check("run_busy", {31'd0, busy}, 0);

    // Reprogram to 20 cycles, then 1000 cycles of undisturbed ticking.
    reprogram("p20", 32'd20, 16'h0013, 16'h0000);
    start_phase(20);
    t0 = n_ticks;
    cyc_wait(1000);
    check("ticks_in_1000", ((n_ticks - t0 >= 49) && (n_ticks - t0 <= 51)) ? 1 : 0, 1);
    check("tick_count_total", tick_count, n_ticks - (tick ? 1 : 0));
    check("div_first_three", (div_at.size() >= 3) ? 1 : 0, 1);
    if (div_at.size() >= 3) begin
      check("div_tick_a", div_at[0], 4);
      check("div_tick_b", div_at[1], 8);
      check("div_tick_c", div_at[2], 12);
    end

    // Snapshot requested two cycles before a timeout.
    tol = 4;
    k = (cyc - base) / 20 + 2;
    c = base + 20 * k - 3;
    while (cyc < c) cyc_wait(1);
    t0 = n_snaps;
    snap_req = 1;
    cyc_wait(1);
    snap_req = 0;
    while (n_snaps == t0 && cyc < c + 20) cyc_wait(1);
    check("snap_seen", (n_snaps != t0) ? 1 : 0, 1);
    check("snap_latency", snap_cyc - c, 5);
    check("snap_range", (snap_val <= 19) ? 1 : 0, 1);
    while (cyc < base + 20 * k + 6) cyc_wait(1);
    check("snap_tick_kept", n_since_base, k + 1);

    // Snapshots at random offsets from the timeout.
    for (int i = 0; i < 6; i++) begin
      k = (cyc - base) / 20 + 2;
      off = int'($urandom_range(1, 19));
      c = base + 20 * k - off;
      while (cyc < c) cyc_wait(1);
      t0 = n_snaps;
      snap_req = 1;
      cyc_wait(1);
      snap_req = 0;
      while (n_snaps == t0 && cyc < c + 20) cyc_wait(1);
      lat = (off == 1) ? 6 : (off == 2) ? 7 : 5;
      check("rsnap_latency", snap_cyc - c, lat);
      check("rsnap_range", (snap_val <= 19) ? 1 : 0, 1);
    end
    cyc_wait(45);
    check("rsnap_no_loss", n_since_base, (cyc - base) / 20 + 1);

    // Period below the minimum is clamped, then a random legal period.
    p = int'($urandom_range(0, 15));
    reprogram("clamp", 32'(p), 16'd15, 16'd0);
    start_phase(16);
    cyc_wait(200);
    check("clamp_ticks", n_since_base, (cyc - base) / 16 + 1);
    p = int'($urandom_range(17, 40));
    reprogram("rand_p", 32'(p), 16'(p - 1), 16'd0);
    start_phase(p);
    cyc_wait(300);
    check("rand_p_ticks", n_since_base, (cyc - base) / p + 1);

    // Drop enable while the high period half is being written.
    phase_on = 0;
    wait_tick("halt_sync", 80);
    w0 = wlog.size();
    cfg_period = 32'd24;
    cfg_load = 1;
    cyc_wait(1);
    cfg_load = 0;
    k = 0;
    while (wlog.size() < w0 + 3 && k < 20) begin cyc_wait(1); k++; end
    check_wr("halt_ph", w0 + 2, 3'd3, 16'h0000, 1);
    enable = 0;
    wait_writes(w0 + 5, 20);
    check_wr("halt_ctrl", w0 + 3, 3'd1, 16'h0007, 1);
    check_wr("halt_stop", w0 + 4, 3'd1, 16'h0008, 2);
    cyc_wait(2);
    check("halt_busy", {31'd0, busy}, 0);
    check("halt_cs", {31'd0, tmr_chipselect}, 0);
    tc = n_ticks;
    halted_chk = 1;
    cyc_wait(100);
    check("halt_no_irq", {31'd0, irq_after_halt}, 0);
    check("halt_count_kept", tick_count, tc);
    halted_chk = 0;

    // Re-enable: counter and divider continue from their retained values.
    w0 = wlog.size();
    enable = 1;
    wait_writes(w0 + 4, 20);
    check_wr("reen_pl", w0 + 1, 3'd2, 16'd23, 1);
    wait_tick("reen", 80);
    wait_tick("reen2", 40);

    // Reset in the middle of a snapshot read.
    cyc_wait(3);
    snap_req = 1;
    cyc_wait(1);
    snap_req = 0;
    k = 0;
    while (!(tmr_chipselect && tmr_write_n && tmr_address == 3'd4) && k < 20) begin
      cyc_wait(1);
      k++;
    end
    check("sn_rl_reached", (k < 20) ? 1 : 0, 1);
    reset_n = 0;
    #1;
    check_reset_outputs("mid_reset");
    cyc_wait(2);
    check("mid_reset_irq", {31'd0, tmr_irq}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
